pulse_width_meter: RTL and testbench

PULSE_WIDTH_METER -- requirements
Module: pulse_width_meter

---
 rtl/pulse_width_meter.sv | 96 +++++++++
 tb/tb_pulse_width_meter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_width_meter.sv
// pulse_width_meter: per-channel synchronised pulse-width capture with valid/ack handshake.
// Define PWM_MAX_TRACK_EN to add per-channel peak-width tracking on max_width_o.
module pulse_width_meter #(
  parameter int CH   = 4,
  parameter int W    = 8,
  parameter int SYNC = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [CH-1:0]     psi_i,
  input  logic [CH-1:0]     ack_i,
  input  logic [CH-1:0]     clr_max_i,
  output logic [CH*W-1:0]   width_o,
  output logic [CH-1:0]     valid_o,
  output logic [CH-1:0]     ovf_o,
  output logic [CH-1:0]     overrun_o,
  output logic [CH*W-1:0]   max_width_o
);
  typedef enum logic {IDLE, MEAS} state_e;
`ifndef PWM_MAX_TRACK_EN
  logic unused_clr;
  assign unused_clr = ^clr_max_i;
`endif
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [SYNC-1:0] sync_q;
    logic            psi_s, psi_d_q;
    state_e          state_q, state_d;
    logic [W-1:0]    cnt_q, cnt_d, width_q, width_d;
    logic            sat_q, sat_d, valid_q, valid_d, ovf_q, ovf_d, ovr_q, ovr_d, cap;
    assign psi_s = sync_q[SYNC-1];
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      cap     = 1'b0;
      if (state_q == IDLE) begin
        if (psi_s && !psi_d_q) begin
          cnt_d   = W'(1);
          sat_d   = 1'b0;
          state_d = MEAS;
        end
      end else if (psi_s) begin
        cnt_d = &cnt_q ? cnt_q : cnt_q + W'(1);
        sat_d = sat_q | (&cnt_q);
      end else begin
        cap     = 1'b1;
        state_d = IDLE;
      end
      width_d = cap ? cnt_q : width_q;
      ovf_d   = cap ? sat_q : ovf_q;
      valid_d = cap | (valid_q & ~ack_i[c]);
      // an acknowledged result being replaced is not an overrun
      ovr_d   = (cap & valid_q & ~ack_i[c]) | (ovr_q & ~ack_i[c]);
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        sync_q  <= '0;
        psi_d_q <= 1'b0;
        state_q <= IDLE;
        cnt_q   <= '0;
        sat_q   <= 1'b0;
        width_q <= '0;
        valid_q <= 1'b0;
        ovf_q   <= 1'b0;
        ovr_q   <= 1'b0;
      end else begin
        sync_q  <= (sync_q << 1) | SYNC'(psi_i[c]);
        psi_d_q <= psi_s;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        sat_q   <= sat_d;
        width_q <= width_d;
        valid_q <= valid_d;
        ovf_q   <= ovf_d;
        ovr_q   <= ovr_d;
      end
    end
    assign width_o[c*W +: W] = width_q;
    assign valid_o[c]        = valid_q;
    assign ovf_o[c]          = ovf_q;
    assign overrun_o[c]      = ovr_q;
`ifdef PWM_MAX_TRACK_EN
    logic [W-1:0] max_q, max_d;
    // a clear coinciding with a capture restarts the peak from the new width
    assign max_d = (cap && (clr_max_i[c] || cnt_q > max_q)) ? cnt_q :
                   clr_max_i[c] ? '0 : max_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) max_q <= '0;
      else          max_q <= max_d;
    end
    assign max_width_o[c*W +: W] = max_q;
`else
    assign max_width_o[c*W +: W] = '0;
`endif
  end
endmodule

// File: tb/tb_pulse_width_meter.sv
// tb_pulse_width_meter: directed table plus randomized run against a run-length reference model.
// Two instances (W=8 and W=4) share the stimulus so saturation is exercised alongside normal widths.
module tb_pulse_width_meter;
  localparam int CH = 4, SYNC = 2;
  localparam int WID [2] = '{8, 4};
  logic clk = 1'b0, rst_n = 1'b0;
  logic [CH-1:0] psi = '0, ack = '0, clr = '0;
  logic [CH*8-1:0] w8, m8;
  logic [CH*4-1:0] w4, m4;
  logic [CH-1:0] v8, o8, r8, v4, o4, r4;
  int tests = 0, errors = 0;
  always #5 clk = ~clk;
  pulse_width_meter #(.CH(CH), .W(8), .SYNC(SYNC)) u8 (
    .clk_i(clk), .rst_n_i(rst_n), .psi_i(psi), .ack_i(ack), .clr_max_i(clr),
    .width_o(w8), .valid_o(v8), .ovf_o(o8), .overrun_o(r8), .max_width_o(m8));
  pulse_width_meter #(.CH(CH), .W(4), .SYNC(SYNC)) u4 (
    .clk_i(clk), .rst_n_i(rst_n), .psi_i(psi), .ack_i(ack), .clr_max_i(clr),
    .width_o(w4), .valid_o(v4), .ovf_o(o4), .overrun_o(r4), .max_width_o(m4));
  // reference: psi seen SYNC samples late; a capture ends each run of high samples
  int run [CH];
  bit hist [CH][SYNC];
  bit mv [CH], mr [CH];
  int mw [2][CH], mo [2][CH], mm [2][CH];
  always @(posedge clk or negedge rst_n) begin
    bit seen, cap;
    int n, lim;
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        run[c] = 0; mv[c] = 0; mr[c] = 0;
        for (int k = 0; k < SYNC; k++) hist[c][k] = 0;
        for (int i = 0; i < 2; i++) begin mw[i][c] = 0; mo[i][c] = 0; mm[i][c] = 0; end
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        seen = hist[c][SYNC-1];
        for (int k = SYNC-1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = psi[c];
        n = run[c];
        cap = !seen && n > 0;
        run[c] = seen ? n + 1 : 0;
        for (int i = 0; i < 2; i++) begin
          lim = (1 << WID[i]) - 1;
          if (cap) begin
            mw[i][c] = n > lim ? lim : n;
            mo[i][c] = n > lim;
          end
`ifdef PWM_MAX_TRACK_EN
          if (cap) mm[i][c] = (clr[c] || mw[i][c] > mm[i][c]) ? mw[i][c] : mm[i][c];
          else if (clr[c]) mm[i][c] = 0;
`endif
        end
        if (ack[c]) mr[c] = 0;
        if (cap && mv[c] && !ack[c]) mr[c] = 1;
        mv[c] = cap ? 1'b1 : (ack[c] ? 1'b0 : mv[c]);
      end
    end
  end
  function automatic void chk(string nm, int c, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ch%0d: got %0d, expected %0d", nm, c, act, exp);
    end
  endfunction
  task automatic check_model();
    for (int c = 0; c < CH; c++) begin
      chk("valid8", c, 32'(v8[c]), 32'(mv[c]));
      chk("valid4", c, 32'(v4[c]), 32'(mv[c]));
      chk("overrun8", c, 32'(r8[c]), 32'(mr[c]));
      chk("overrun4", c, 32'(r4[c]), 32'(mr[c]));
      chk("width8", c, 32'(w8[c*8 +: 8]), mw[0][c]);
      chk("width4", c, 32'(w4[c*4 +: 4]), mw[1][c]);
      chk("ovf8", c, 32'(o8[c]), mo[0][c]);
      chk("ovf4", c, 32'(o4[c]), mo[1][c]);
      chk("max8", c, 32'(m8[c*8 +: 8]), mm[0][c]);
      chk("max4", c, 32'(m4[c*4 +: 4]), mm[1][c]);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    check_model();
  endtask
  task automatic pulse(input int c, input int len);
    psi[c] = 1'b1;
    repeat (len) tick();
    psi[c] = 1'b0;
  endtask
  task automatic ackc(input int c);
    ack[c] = 1'b1;
    tick();
    ack[c] = 1'b0;
  endtask
  task automatic wait_valid(input int c, output int lat);
    lat = 1;
    while (!v8[c] && lat < 12) begin tick(); lat++; end
  endtask
  typedef struct {
    int ch; int len; bit ack_cap; bit ack_after;
    int w8; int w4; bit ovf4; bit ovr;
  } vec_t;
  vec_t vecs [8];
  int lat;
  initial begin
    vecs = '{
      '{0, 15, 0, 1, 15, 15, 0, 0},
      '{0, 16, 0, 1, 16, 15, 1, 0},
      '{1, 20, 0, 1, 20, 15, 1, 0},
      '{1,  3, 0, 1,  3,  3, 0, 0},
      '{2,  6, 0, 0,  6,  6, 0, 0},
      '{2,  9, 0, 1,  9,  9, 0, 1},
      '{3,  2, 0, 0,  2,  2, 0, 0},
      '{3,  7, 1, 1,  7,  7, 0, 0}};
    repeat (2) @(negedge clk);
    tick();
    chk("reset_zero", 0, 32'(|{w8, v8, o8, r8, m8, w4, v4, o4, r4, m4}), 0);
    rst_n = 1'b1;
    repeat (3) tick();
    // the drop cycle counts as cycle 1
    pulse(0, 5);
    wait_valid(0, lat);
    chk("latency", 0, lat, SYNC + 2);
    chk("w5", 0, 32'(w8[7:0]), 5);
    chk("ovf5", 0, 32'(o8[0]), 0);
    ackc(0);
    chk("ack_clears", 0, 32'(v8[0]), 0);
    ackc(0);
    chk("ack_idle", 0, 32'(v8[0]), 0);
    foreach (vecs[j]) begin
      pulse(vecs[j].ch, vecs[j].len);
      tick();
      tick();
      ack[vecs[j].ch] = vecs[j].ack_cap;
      tick();
      ack[vecs[j].ch] = 1'b0;
      chk("tbl_w8", vecs[j].ch, 32'(w8[vecs[j].ch*8 +: 8]), vecs[j].w8);
      chk("tbl_w4", vecs[j].ch, 32'(w4[vecs[j].ch*4 +: 4]), vecs[j].w4);
      chk("tbl_ovf4", vecs[j].ch, 32'(o4[vecs[j].ch]), 32'(vecs[j].ovf4));
      chk("tbl_ovf8", vecs[j].ch, 32'(o8[vecs[j].ch]), 0);
      chk("tbl_valid", vecs[j].ch, 32'(v8[vecs[j].ch]), 1);
      chk("tbl_ovr", vecs[j].ch, 32'(r8[vecs[j].ch]), 32'(vecs[j].ovr));
      if (vecs[j].ack_after) begin
        ackc(vecs[j].ch);
        chk("tbl_valid_ack", vecs[j].ch, 32'(v8[vecs[j].ch]), 0);
        chk("tbl_ovr_ack", vecs[j].ch, 32'(r8[vecs[j].ch]), 0);
      end
    end
    psi[0] = 1'b1;
    repeat (SYNC + 4) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_zero", 0, 32'(|{w8, v8, o8, r8, m8, w4, v4, o4, r4, m4}), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    psi[0] = 1'b0;
    wait_valid(0, lat);
    chk("post_rst_w8", 0, 32'(w8[7:0]), 3);
    chk("post_rst_w4", 0, 32'(w4[3:0]), 3);
    ackc(0);
    foreach (vecs[j]) if (j < 3) begin
      pulse(1, j == 0 ? 10 : j == 1 ? 4 : 12);
      repeat (3) tick();
      ackc(1);
    end
`ifdef PWM_MAX_TRACK_EN
    chk("max12", 1, 32'(m8[15:8]), 12);
    pulse(1, 2);
    tick();
    tick();
    clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    chk("max_clr_cap", 1, 32'(m8[15:8]), 2);
    chk("w_clr_cap", 1, 32'(w8[15:8]), 2);
    clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    chk("max_clr", 1, 32'(m8[15:8]), 0);
`else
    clr = '1;
    tick();
    clr = '0;
    chk("max_off", 1, 32'(|{m8, m4}), 0);
`endif
    for (int t = 0; t < 4000; t++) begin
      tick();
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(5) == 0) psi[c] = ~psi[c];
        ack[c] = $urandom_range(3) == 0;
        clr[c] = $urandom_range(15) == 0;
      end
      rst_n = $urandom_range(399) != 0;
    end
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
